// File: rtl/fp_div_pkg.sv
// Shared constants, state encoding and IEEE-754 single field helpers for the
// sequential divide unit.
package fp_div_pkg;

  localparam int BIAS = 127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Partial remainder and mantissa widths of the iteration stage
  localparam int RW = 27;
  localparam int MW = 24;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DIV  = 2'd1;
  localparam state_t ST_NORM = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // out_flags = {invalid, div_by_zero, overflow, underflow}
  localparam int FLG_INV = 3;
  localparam int FLG_DZ  = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] f_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp_div_nr_step.sv
// One combinational non-restoring division iteration: shift in a dividend
// bit, then subtract or add the divisor depending on the remainder sign.
module fp_div_nr_step
  import fp_div_pkg::*;
#(
  parameter int RWID = RW,
  parameter int MWID = MW
) (
  input  logic signed [RWID-1:0] r,
  input  logic                   next_bit,
  input  logic        [MWID-1:0] mb,
  output logic signed [RWID-1:0] r_nxt,
  output logic                   qbit
);

  logic            sub;
  logic            carry;
  logic [RWID-1:0] sh;
  logic [RWID-1:0] addend;
  logic [RWID-1:0] sum;

  // Subtraction is add of the one's complement with carry-in set
  always_comb begin
    sub    = ~r[RWID-1];
    sh     = {r[RWID-2:0], next_bit};
    addend = sub ? ~{{(RWID-MWID){1'b0}}, mb} : {{(RWID-MWID){1'b0}}, mb};
    carry  = sub;
    sum    = '0;
    for (int i = 0; i < RWID; i++) begin
      sum[i] = sh[i] ^ addend[i] ^ carry;
      carry  = (sh[i] & addend[i]) | (sh[i] & carry) | (addend[i] & carry);
    end
    r_nxt = $signed(sum);
    qbit  = ~sum[RWID-1];
  end

endmodule

// File: rtl/fp_div_seq_ctrl.sv
// Sequential IEEE-754 single divide: unpack/classify, 26 non-restoring
// iterations through one shared stage, normalise, then hold for writeback.
module fp_div_seq_ctrl
  import fp_div_pkg::*;
#(
  parameter int QBITS = 26,
  parameter int BIAS  = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic [3:0]  out_flags
);

  localparam int CW = $clog2(QBITS);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic signed [RW-1:0] r_q, r_d;
  logic [QBITS-1:0]  q_q, q_d;
  logic              sign_q, sign_d;
  logic [7:0]        ea_q, ea_d;
  logic [7:0]        eb_q, eb_d;
  logic [MW-1:0]     mb_q, mb_d;
  logic              ma_lsb_q, ma_lsb_d;
  logic [31:0]       res_q, res_d;
  logic [3:0]        flags_q, flags_d;
  logic              out_valid_q, out_valid_d;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_in;
  logic        step_bit, qbit;
  logic signed [RW-1:0] r_nxt;
  logic signed [9:0]    e_norm;
  logic [22:0]          frac_norm;

  always_comb begin
    ea      = f_exp(in_a);
    eb      = f_exp(in_b);
    fa      = f_frac(in_a);
    fb      = f_frac(in_b);
    sign_in = f_sign(in_a) ^ f_sign(in_b);
    a_nan   = (ea == 8'hFF) && (fa != '0);
    b_nan   = (eb == 8'hFF) && (fb != '0);
    a_inf   = (ea == 8'hFF) && (fa == '0);
    b_inf   = (eb == 8'hFF) && (fb == '0);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
  end

  // Only the first iteration consumes a real dividend bit; the rest shift in zeros
  assign step_bit = (cnt_q == '0) ? ma_lsb_q : 1'b0;

  fp_div_nr_step #(.RWID(RW), .MWID(MW)) u_step (
    .r        (r_q),
    .next_bit (step_bit),
    .mb       (mb_q),
    .r_nxt    (r_nxt),
    .qbit     (qbit)
  );

  always_comb begin
    e_norm = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + $signed(10'(BIAS))
             - $signed({9'b0, ~q_q[QBITS-1]});
    frac_norm = q_q[QBITS-1] ? q_q[QBITS-2:2] : q_q[QBITS-3:1];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    sign_d      = sign_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    mb_d        = mb_q;
    ma_lsb_d    = ma_lsb_q;
    res_d       = res_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = sign_in;
          flags_d = '0;
          state_d = ST_DONE;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_d            = QNAN;
            flags_d[FLG_INV] = 1'b1;
          end else if (a_inf) begin
            res_d = {sign_in, POS_INF[30:0]};
          end else if (b_zero) begin
            res_d           = {sign_in, POS_INF[30:0]};
            flags_d[FLG_DZ] = 1'b1;
          end else if (a_zero || b_inf) begin
            res_d = {sign_in, 31'b0};
          end else begin
            // The top 23 dividend bits are always below mb, so they are
            // preloaded as the remainder instead of iterating over them.
            ea_d     = ea;
            eb_d     = eb;
            mb_d     = {1'b1, fb};
            ma_lsb_d = fa[0];
            r_d      = $signed({4'b0000, 1'b1, fa[22:1]});
            q_d      = '0;
            cnt_d    = '0;
            state_d  = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        r_d   = r_nxt;
        q_d   = {q_q[QBITS-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(QBITS-1)) begin
          cnt_d   = '0;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        flags_d = '0;
        if (e_norm >= 10'sd255) begin
          res_d            = {sign_q, POS_INF[30:0]};
          flags_d[FLG_OVF] = 1'b1;
        end else if (e_norm <= 10'sd0) begin
          res_d            = {sign_q, 31'b0};
          flags_d[FLG_UNF] = 1'b1;
        end else begin
          res_d = {sign_q, e_norm[7:0], frac_norm};
        end
        state_d = ST_DONE;
      end
      default: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      mb_q        <= '0;
      ma_lsb_q    <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      sign_q      <= sign_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      mb_q        <= mb_d;
      ma_lsb_q    <= ma_lsb_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_q     = res_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_fp_div_seq_ctrl.sv
// Directed and randomized checks of fp_div_seq_ctrl against an arithmetic
// reference model of IEEE-754 single divide with truncation and flushing.
module tb_fp_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic [3:0]  out_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_div_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_flags (out_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {special, flags[3:0], result[31:0]}
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [63:0] ma, mb, quo, frac;
    bit          an, bn, ai, bi, az, bz;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 4'b1000, 32'h7FC00000};
    if (ai) return {1'b1, 4'b0000, s, 31'h7F800000};
    if (bz) return {1'b1, 4'b0100, s, 31'h7F800000};
    if (az || bi) return {1'b1, 4'b0000, s, 31'h0};
    ma  = 64'h800000 + 64'(a[22:0]);
    mb  = 64'h800000 + 64'(b[22:0]);
    quo = (ma * 64'd33554432) / mb;
    e   = ea - eb + 127;
    if (quo >= 64'd33554432) frac = (quo / 4) % 64'h800000;
    else begin
      frac = (quo / 2) % 64'h800000;
      e    = e - 1;
    end
    if (e >= 255) return {1'b0, 4'b0010, s, 31'h7F800000};
    if (e <= 0) return {1'b0, 4'b0001, s, 31'h0};
    return {1'b0, 4'b0000, s, e[7:0], frac[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [3:0] exp_f,
                        input int exp_lat, input int hold);
    int n;
    bit busy_ok;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n        = 0;
    busy_ok  = 1'b1;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_ok = 1'b0;
      in_a = $urandom;
      in_b = $urandom;
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("in_ready_busy", {31'b0, busy_ok}, 32'd1);
    chk("out_q", out_q, exp_q);
    chk("out_flags", {28'b0, out_flags}, {28'b0, exp_f});
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_q", out_q, exp_q);
      chk("hold_flags", {28'b0, out_flags}, {28'b0, exp_f});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_valid", {31'b0, out_valid}, 32'd0);
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_model(input logic [31:0] a, input logic [31:0] b);
    logic [36:0] m;
    m = model(a, b);
    run_op(a, b, m[31:0], m[35:32], m[36] ? 1 : 28, 0);
  endtask

  initial begin
    int n;
    bit quiet;
    logic [31:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (3) step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_q", out_q, 32'd0);
    chk("rst_out_flags", {28'b0, out_flags}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    run_op(32'h40C00000, 32'h40400000, 32'h40000000, 4'b0000, 28, 0);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 28, 0);
    run_op(32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000, 28, 0);
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1, 0);
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, 0);
    run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 28, 0);
    run_op(32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 28, 0);
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, 0);
    run_op(32'hFF800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1, 0);
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1, 0);
    run_op(32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 1, 0);
    run_op(32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, 1, 0);

    // Backpressure, then an immediate follow-on operation
    run_op(32'h40C00000, 32'h40400000, 32'h40000000, 4'b0000, 28, 5);
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1, 3);
    run_op(32'h40C00000, 32'h40400000, 32'h40000000, 4'b0000, 28, 0);

    // Abort mid-iteration
    in_a     = 32'h40C00000;
    in_b     = 32'h40400000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    quiet = 1'b1;
    for (n = 0; n < 40; n++) begin
      if (out_valid) quiet = 1'b0;
      step();
    end
    chk("abort_no_output", {31'b0, quiet}, 32'd1);
    run_op(32'h40C00000, 32'h40400000, 32'h40000000, 4'b0000, 28, 0);

    // Random finite normals
    for (int i = 0; i < 24; i++) begin
      ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      run_model(ra, rb);
    end
    // Random bit patterns, with zero/inf exponents forced now and then
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra[30:23] = 8'h00;
        1: rb[30:23] = 8'hFF;
        2: rb[30:23] = 8'h00;
        default: ;
      endcase
      run_model(ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
